// File: rtl/fetch_buffer_pkg.sv
// Shared fetch/decode definitions: word widths, reset PC and the queued entry.
package fetch_buffer_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [0:PC_W-1] RESET_PC = 32'h80020000;

  // One queued instruction: the PC it was fetched from and the word itself.
  typedef struct packed {
    logic [0:PC_W-1]    pc;
    logic [0:INSTR_W-1] instr;
  } fb_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and decode-side signals of the instruction buffer.
// master = fetch/decode environment, slave = the buffer itself.
interface fetch_buffer_if #(
  parameter int ADDR_W = 32
);
  import fetch_buffer_pkg::*;

  logic                 in_valid;
  logic [0:ADDR_W-1]    pc_in;
  logic [0:INSTR_W-1]   instr_in;
  logic                 flush;
  logic                 out_ready;
  logic                 out_valid;
  logic [0:ADDR_W-1]    pc_out;
  logic [0:INSTR_W-1]   instr_out;
  logic                 stall;
  logic                 overflow_err;

  modport master (
    output in_valid, pc_in, instr_in, flush, out_ready,
    input  out_valid, pc_out, instr_out, stall, overflow_err
  );

  modport slave (
    input  in_valid, pc_in, instr_in, flush, out_ready,
    output out_valid, pc_out, instr_out, stall, overflow_err
  );

endinterface

// File: rtl/fetch_buffer_fifo_ram.sv
// Entry storage for the fetch buffer: one synchronous write port and one
// asynchronous read port so the head entry is visible without a read cycle.
module fifo_ram
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fb_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output fb_entry_t        rdata
);

  fb_entry_t mem [DEPTH];

  // Write the pushed entry; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction buffer between fetch and decode. Queues (PC, instr) pairs,
// shows the head entry to decode, and raises stall one entry early so the
// word already in flight from memory always finds a free slot.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  logic      not_empty;
  logic      full;
  logic      pop;
  logic      push;
  logic      drop;
  fb_entry_t wr_entry;
  fb_entry_t rd_entry;

  assign not_empty = (count_reg != '0);
  assign full      = (count_reg == FULL_CNT);
  // A pop frees the head this cycle, so a push into a full queue still fits.
  assign pop       = not_empty && bus.out_ready && !bus.flush;
  assign push      = bus.in_valid && !bus.flush && (!full || pop);
  assign drop      = bus.in_valid && !bus.flush && full && !pop;

  assign wr_entry.pc    = PC_W'(bus.pc_in);
  assign wr_entry.instr = bus.instr_in;

  fifo_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata (wr_entry),
    .raddr (rd_ptr_reg),
    .rdata (rd_entry)
  );

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  // Sticky record of a dropped word; only reset clears it, flush does not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign bus.out_valid    = not_empty;
  assign bus.pc_out       = not_empty ? ADDR_W'(rd_entry.pc) : '0;
  assign bus.instr_out    = not_empty ? rd_entry.instr : '0;
  assign bus.stall        = (count_reg >= STALL_CNT);
  assign bus.overflow_err = overflow_reg;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus a random run, all checked
// against a queue-based model of the buffer's contents.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_buffer_if #(.ADDR_W(32)) bus ();

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } m_entry_t;

  m_entry_t mq[$];
  bit       m_ovf = 1'b0;
  int       total = 0;
  int       bad = 0;

  function automatic logic exp_valid();
    return mq.size() != 0;
  endfunction
  function automatic logic [31:0] exp_pc();
    return (mq.size() != 0) ? mq[0].pc : 32'h0;
  endfunction
  function automatic logic [31:0] exp_instr();
    return (mq.size() != 0) ? mq[0].instr : 32'h0;
  endfunction
  function automatic logic exp_stall();
    return mq.size() >= DEPTH - 1;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic rdy);
    bus.in_valid  = v;
    bus.pc_in     = pc;
    bus.instr_in  = ins;
    bus.flush     = fl;
    bus.out_ready = rdy;
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    bit popped;
    bit was_full;
    m_entry_t e;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      popped   = (mq.size() != 0) && bus.out_ready;
      was_full = (mq.size() == DEPTH);
      if (bus.in_valid && was_full && !popped) m_ovf = 1'b1;
      if (popped) void'(mq.pop_front());
      if (bus.in_valid && (!was_full || popped)) begin
        e.pc = bus.pc_in;
        e.instr = bus.instr_in;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h80020000, 32'h11111111, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h80020004, 32'h22222222, 1'b0, 1'b0);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", bus.stall); end
    total++; if (bus.pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", bus.pc_out); end
    total++; if (bus.instr_out !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", bus.instr_out); end
    total++; if (bus.overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", bus.overflow_err); end
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid: got %0b want 0", bus.out_valid); end
    $display("test_reset done");
  endtask

  task automatic test_fill_stall();
    logic [31:0] pc;
    logic        want_stall;
    for (int i = 0; i < 4; i++) begin
      pc = RESET_PC + 32'(4 * i);
      drive(1'b1, pc, pc ^ 32'h00A5_0000, 1'b0, 1'b0);
      tick();
      want_stall = (i >= 2);
      total++; if (bus.stall !== want_stall) begin bad++; $display("FAIL fill_stall[%0d]: got %0b want %0b", i, bus.stall, want_stall); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL fill_valid[%0d]: got %0b want 1", i, bus.out_valid); end
      total++; if (bus.pc_out !== RESET_PC) begin bad++; $display("FAIL fill_head[%0d]: got %h want %h", i, bus.pc_out, RESET_PC); end
      $display("fill push pc=%h stall=%0b", pc, bus.stall);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    total++; if (bus.overflow_err !== 1'b0) begin bad++; $display("FAIL fill_ovf: got %0b want 0", bus.overflow_err); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] want;
    drive(1'b1, 32'h80020010, 32'hAAAA0010, 1'b0, 1'b1);
    tick();
    total++; if (bus.pc_out !== 32'h80020004) begin bad++; $display("FAIL fullpp_head: got %h want 80020004", bus.pc_out); end
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL fullpp_stall: got %0b want 1", bus.stall); end
    total++; if (bus.overflow_err !== 1'b0) begin bad++; $display("FAIL fullpp_ovf: got %0b want 0", bus.overflow_err); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      want = 32'h80020004 + 32'(4 * i);
      total++; if (bus.pc_out !== want) begin bad++; $display("FAIL fullpp_drain_pc[%0d]: got %h want %h", i, bus.pc_out, want); end
      total++; if (bus.instr_out !== exp_instr()) begin bad++; $display("FAIL fullpp_drain_instr[%0d]: got %h want %h", i, bus.instr_out, exp_instr()); end
      $display("drain pc=%h instr=%h", bus.pc_out, bus.instr_out);
      tick();
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fullpp_empty: got %0b want 0", bus.out_valid); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL fullpp_unstall: got %0b want 0", bus.stall); end
  endtask

  task automatic test_order_wrap();
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    logic [31:0] base = 32'h80021000;
    logic [31:0] want;
    while (popped < 10 && cyc < 100) begin
      drive((pushed < 10) && !bus.stall, base + 32'(4 * pushed), $urandom, 1'b0, cyc[0]);
      total++; if (bus.pc_out !== exp_pc()) begin bad++; $display("FAIL order_model_pc: got %h want %h", bus.pc_out, exp_pc()); end
      if (bus.out_valid && bus.out_ready) begin
        want = base + 32'(4 * popped);
        total++; if (bus.pc_out !== want) begin bad++; $display("FAIL order_seq[%0d]: got %h want %h", popped, bus.pc_out, want); end
        $display("order pop pc=%h", bus.pc_out);
        popped++;
      end
      if (bus.in_valid) pushed++;
      tick();
      cyc++;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    total++; if (popped != 10) begin bad++; $display("FAIL order_count: got %0d want 10", popped); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL order_empty: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_flush_push();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h80030000 + 32'(4 * i), 32'h0000_1000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL flush_prestall: got %0b want 1", bus.stall); end
    drive(1'b1, 32'h8003000C, 32'h8C220004, 1'b1, 1'b0);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0b want 0", bus.out_valid); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %0b want 0", bus.stall); end
    total++; if (bus.pc_out !== 32'h0) begin bad++; $display("FAIL flush_pc: got %h want 0", bus.pc_out); end
    drive(1'b1, 32'h80030100, 32'h12345678, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.pc_out !== 32'h80030100) begin bad++; $display("FAIL flush_next_pc: got %h want 80030100", bus.pc_out); end
    total++; if (bus.instr_out !== 32'h12345678) begin bad++; $display("FAIL flush_next_instr: got %h want 12345678", bus.instr_out); end
    $display("flush then push head pc=%h", bus.pc_out);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_drain: got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h80040000 + 32'(4 * i), 32'h0000_2000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    total++; if (bus.overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_before: got %0b want 0", bus.overflow_err); end
    drive(1'b1, 32'h80040010, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    total++; if (bus.overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0b want 1", bus.overflow_err); end
    total++; if (bus.pc_out !== 32'h80040000) begin bad++; $display("FAIL ovf_head: got %h want 80040000", bus.pc_out); end
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL ovf_stall: got %0b want 1", bus.stall); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    total++; if (bus.overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", bus.overflow_err); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_flushed: got %0b want 0", bus.out_valid); end
    $display("overflow sticky=%0b after flush", bus.overflow_err);
  endtask

  task automatic test_random();
    logic [31:0] pc = 32'h80050000;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, pc, $urandom, ($urandom % 20) == 0, ($urandom % 2) == 1);
      if (bus.in_valid) pc = pc + 32'd4;
      tick();
      total++; if (bus.out_valid !== exp_valid()) begin bad++; $display("FAIL rnd_valid c=%0d: got %0b want %0b", c, bus.out_valid, exp_valid()); end
      total++; if (bus.pc_out !== exp_pc()) begin bad++; $display("FAIL rnd_pc c=%0d: got %h want %h", c, bus.pc_out, exp_pc()); end
      total++; if (bus.instr_out !== exp_instr()) begin bad++; $display("FAIL rnd_instr c=%0d: got %h want %h", c, bus.instr_out, exp_instr()); end
      total++; if (bus.stall !== exp_stall()) begin bad++; $display("FAIL rnd_stall c=%0d: got %0b want %0b", c, bus.stall, exp_stall()); end
      total++; if (bus.overflow_err !== m_ovf) begin bad++; $display("FAIL rnd_ovf c=%0d: got %0b want %0b", c, bus.overflow_err, m_ovf); end
    end
    $display("random run done, model depth=%0d ovf=%0b", mq.size(), m_ovf);
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_fill_stall();
    test_full_push_pop();
    test_order_wrap();
    test_flush_push();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction buffer between the fetch stage and decode. Captures each (PC, instruction word) pair returned by instruction memory, queues up to DEPTH entries, and presents them in order to decode with a valid/ready handshake. Raises `stall` back to fetch early enough that the one word already in flight from memory always has a free slot. Supports a single-cycle flush for branch/jump redirects.

## Interface
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `ADDR_W`, 32: PC width, big-endian bit order `[0:ADDR_W-1]`.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: memory returns an instruction this cycle.
- `pc_in` input `[0:31]`: PC of the returned word, taken from fetch `pc_out`.
- `instr_in` input `[0:31]`: instruction word from memory.
- `flush` input 1: discard all queued and incoming entries.
- `out_ready` input 1: decode accepts the head entry this cycle.
- `out_valid` output 1: head entry present.
- `pc_out` output `[0:31]`: head entry PC.
- `instr_out` output `[0:31]`: head entry instruction.
- `stall` output 1: to fetch `stall`; fetch holds its PC while high.
- `overflow_err` output 1: sticky; a push was dropped.

## Operation
- Circular buffer with `rd_ptr`, `wr_ptr` (log2 DEPTH bits, wrap modulo DEPTH) and `count` (0..DEPTH, log2 DEPTH + 1 bits).
- Push: `in_valid && !flush && (count < DEPTH || pop)`. Writes `{pc_in, instr_in}` at `wr_ptr`, then increments `wr_ptr`.
- Pop: `out_valid && out_ready && !flush`. Increments `rd_ptr`.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when full: both take effect; `count` stays DEPTH.
- Push attempted when full with no pop: word dropped, state unchanged, `overflow_err` set until reset.
- `flush` has priority over everything. `count`, `rd_ptr` and `wr_ptr` clear to 0. Any same-cycle `in_valid` word is discarded. `overflow_err` is not cleared.
- `out_valid = (count != 0)`. `pc_out`/`instr_out` are the entry at `rd_ptr`, show-ahead. They are 0 when empty.
- `stall = (count >= DEPTH-1)`. This leaves one slot for the word already in flight, given fetch's one-cycle memory latency.
- Reset (`rst_n` low at an edge): `count`/pointers 0, `out_valid` 0, `pc_out`/`instr_out` 0, `stall` 0, `overflow_err` 0. Storage contents are don't-care. Reset mid-stream drops everything.

## Timing
- Push-to-output latency is 1 cycle. A word pushed at edge N is visible with `out_valid` high after edge N. There is no combinational bypass from `in_*` to `out_*`.
- `stall` is derived from registered `count` only and has no combinational path from any input. It asserts the cycle after the push that brings `count` to DEPTH-1. It deasserts the cycle after the pop that brings `count` to DEPTH-2.
- Flush: `out_valid` is 0 after the flush edge. New pushes are accepted from the next cycle.
- Throughput is 1 entry/cycle sustained when decode holds `out_ready` high.

## Structure
- Shared package holds `INSTR_W = 32`, `RESET_PC = 32'h80020000`, and the `{pc, instr}` entry typedef. Fetch and decode use the same definitions.
- One natural sub-module, `fifo_ram`: DEPTH × 64-bit storage with one synchronous write port and one asynchronous read port. Pointer and count logic stay in `fetch_buffer`.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `in_valid`=1. Required: `out_valid`=0, `stall`=0, `pc_out`=0, `overflow_err`=0, and nothing is queued after release.
- **Fill/stall:** push pc 0x80020000, 0x80020004, 0x80020008 with `out_ready`=0. Required: `stall` goes 1 after the third push (DEPTH=4). A fourth push of 0x8002000C is accepted, giving `count`=4.
- **Ordering and wrap:** push 10 sequential PCs while popping every other cycle. Required: decode sees PCs strictly ascending by 4 with no loss or duplication, across at least two pointer wraps.
- **Full push+pop:** at `count`=4, assert `in_valid` and `out_ready` together. Required: `count` stays 4, the head advances, the new word is at the tail, and `overflow_err` stays 0.
- **Overflow:** at `count`=4, `in_valid`=1 and `out_ready`=0. Required: the word is dropped, `overflow_err`=1 and sticky through a later flush.
- **Flush with push:** at `count`=3, assert `flush` and `in_valid` together with `instr_in`=0x8C220004. Required: next cycle `out_valid`=0, `stall`=0, and the next push is the first entry out.
